// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Four-source interrupt controller. Synchronises and latches
//               requests, masks and prioritises them (bit 0 highest), and
//               runs the req/ack entry handshake and iret return with an
//               in-service register.
//               Optional macro IRQ_CTRL_NESTING_EN enables strict
//               higher-priority preemption while sources are in service.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_TRIG   = 1'b1
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [3:0] in_irq,
    input  logic [3:0] in_mask,
    input  logic       in_ie,
    input  logic [3:0] in_clr,
    input  logic       in_int_ack,
    input  logic       in_iret,
    output logic       out_int_req,
    output logic [1:0] out_code,
    output logic       out_enter,
    output logic [3:0] out_pending,
    output logic [3:0] out_isr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ENTER = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] isr_q, isr_d;
    state_t     state_q, state_d;
    logic       int_req_q, int_req_d;
    logic [1:0] code_q, code_d;
    logic       enter_q, enter_d;

    logic [3:0] sync_last;
    logic [3:0] irq_rise;
    logic [3:0] eligible;
    logic [1:0] winner;
    logic [1:0] isr_low;
    logic       preempt_ok;
    logic       withdraw;
    logic [3:0] ack_set;
    logic [3:0] isr_set;

    // Synchroniser shift chain plus one delay flop for rising-edge detection
    always_comb begin
        sync_d[0] = in_irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign irq_rise  = sync_last & ~prev_q;

    // Pending: edge mode latches rises (a rise beats ack/clr), level mode mirrors the line
    generate
        if (EDGE_TRIG) begin : g_edge
            always_comb begin
                pending_d = irq_rise | (pending_q & ~ack_set & ~in_clr);
            end
        end else begin : g_level
            always_comb begin
                pending_d = sync_last;
            end
        end
    endgenerate

    assign eligible = pending_q & ~in_mask & ~isr_q;

    // Lowest set index wins for both the eligible set and the in-service set
    always_comb begin
        winner  = 2'd0;
        isr_low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) winner  = 2'(i);
            if (isr_q[i])    isr_low = 2'(i);
        end
    end

`ifdef IRQ_CTRL_NESTING_EN
    // Only a strictly higher-priority source may preempt an active handler
    assign preempt_ok = (isr_q == 4'b0000) || (winner < isr_low);
`else
    // No nesting: wait until every handler has returned
    assign preempt_ok = (isr_q == 4'b0000);
`endif

    // A raised request is dropped if interrupts go off or its source stops being eligible
    assign withdraw = !in_ie || !eligible[code_q];

    // Entry handshake sequencing; outputs are computed alongside the next state
    always_comb begin
        state_d   = state_q;
        int_req_d = int_req_q;
        code_d    = code_q;
        enter_d   = 1'b0;
        ack_set   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (in_ie && (eligible != 4'b0000) && preempt_ok) begin
                    state_d   = ST_REQ;
                    int_req_d = 1'b1;
                    code_d    = winner;
                end
            end
            ST_REQ: begin
                if (withdraw) begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end else if (in_int_ack) begin
                    state_d   = ST_ENTER;
                    int_req_d = 1'b0;
                    enter_d   = 1'b1;
                    ack_set   = 4'b0001 << code_q;
                end
            end
            ST_ENTER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase
    end

    // In-service: apply the entry set first, then iret clears the lowest set bit
    always_comb begin
        isr_set = isr_q | ack_set;
        isr_d   = in_iret ? (isr_set & (isr_set - 4'd1)) : isr_set;
    end

    // State registers
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync_q    <= '0;
            prev_q    <= 4'b0000;
            pending_q <= 4'b0000;
            isr_q     <= 4'b0000;
            state_q   <= ST_IDLE;
            int_req_q <= 1'b0;
            code_q    <= 2'b00;
            enter_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            state_q   <= state_d;
            int_req_q <= int_req_d;
            code_q    <= code_d;
            enter_q   <= enter_d;
        end
    end

    assign out_int_req = int_req_q;
    assign out_code    = code_q;
    assign out_enter   = enter_q;
    assign out_pending = pending_q;
    assign out_isr     = isr_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller
//               (SYNC_STAGES=2, EDGE_TRIG=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       ie;
    logic [3:0] clr;
    logic       ack;
    logic       iret;
    logic       int_req;
    logic [1:0] code;
    logic       enter;
    logic [3:0] pending;
    logic [3:0] isr;

    int nvec;
    int nerr;

    irq_controller #(
        .SYNC_STAGES(2),
        .EDGE_TRIG  (1'b1)
    ) dut (
        .in_clk     (clk),
        .in_rst_n   (rst_n),
        .in_irq     (irq),
        .in_mask    (mask),
        .in_ie      (ie),
        .in_clr     (clr),
        .in_int_ack (ack),
        .in_iret    (iret),
        .out_int_req(int_req),
        .out_code   (code),
        .out_enter  (enter),
        .out_pending(pending),
        .out_isr    (isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        irq   = 4'b0000;
        mask  = 4'b0000;
        ie    = 1'b1;
        clr   = 4'b0000;
        ack   = 1'b0;
        iret  = 1'b0;

        // Reset state
        tick(3);
        chk("rst_req",     {3'b0, int_req}, 4'h0);
        chk("rst_code",    {2'b0, code},    4'h0);
        chk("rst_enter",   {3'b0, enter},   4'h0);
        chk("rst_pending", pending,         4'h0);
        chk("rst_isr",     isr,             4'h0);
        rst_n = 1'b1;
        tick(2);

        // Reset asserted while in REQ
        irq = 4'b0100;
        tick(3);
        chk("lat_pending", pending, 4'b0100);
        chk("lat_noreq",   {3'b0, int_req}, 4'h0);
        tick(1);
        chk("mid_req",  {3'b0, int_req}, 4'h1);
        chk("mid_code", {2'b0, code},    4'h2);
        rst_n = 1'b0;
        #1;
        chk("async_req",     {3'b0, int_req}, 4'h0);
        chk("async_code",    {2'b0, code},    4'h0);
        chk("async_pending", pending,         4'h0);
        chk("async_isr",     isr,             4'h0);
        irq = 4'b0000;
        tick(1);
        rst_n = 1'b1;
        tick(3);

        // Global enable off blocks requests; software clear drops pending
        ie  = 1'b0;
        irq = 4'b1000;
        tick(4);
        chk("ie0_pending", pending, 4'b1000);
        chk("ie0_noreq",   {3'b0, int_req}, 4'h0);
        clr = 4'b1000;
        irq = 4'b0000;
        tick(1);
        clr = 4'b0000;
        chk("clr_pending", pending, 4'h0);
        ie = 1'b1;
        tick(3);
        chk("clr_noreq", {3'b0, int_req}, 4'h0);

        // Priority: sources 1 and 3 together
        irq = 4'b1010;
        tick(3);
        chk("pri_pending", pending, 4'b1010);
        tick(1);
        chk("pri_req",  {3'b0, int_req}, 4'h1);
        chk("pri_code", {2'b0, code},    4'h1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        irq = 4'b0000;
        chk("pri_enter",   {3'b0, enter},   4'h1);
        chk("pri_reqlow",  {3'b0, int_req}, 4'h0);
        chk("pri_isr",     isr,             4'b0010);
        chk("pri_pending2", pending,        4'b1000);
        tick(1);
        chk("pri_enter_end", {3'b0, enter}, 4'h0);
        tick(1);
        chk("pri_blocked", {3'b0, int_req}, 4'h0);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("pri_iret_isr", isr, 4'h0);
        tick(1);
        chk("pri_req3",  {3'b0, int_req}, 4'h1);
        chk("pri_code3", {2'b0, code},    4'h3);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("pri_isr3", isr,     4'b1000);
        chk("pri_pnd3", pending, 4'h0);
        tick(1);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("pri_isr_empty", isr, 4'h0);
        tick(2);

        // Mask withdraws a raised request; unmask re-raises it
        irq = 4'b0100;
        tick(4);
        chk("msk_req",  {3'b0, int_req}, 4'h1);
        chk("msk_code", {2'b0, code},    4'h2);
        mask = 4'b0100;
        ack  = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("msk_withdraw", {3'b0, int_req}, 4'h0);
        chk("msk_noisr",    isr,             4'h0);
        chk("msk_pending",  pending,         4'b0100);
        mask = 4'b0000;
        tick(1);
        chk("msk_rereq",  {3'b0, int_req}, 4'h1);
        chk("msk_recode", {2'b0, code},    4'h2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        irq = 4'b0000;
        chk("msk_isr", isr, 4'b0100);
        tick(1);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        tick(2);

        // Nesting: source 1 arrives while source 3 is in service
        irq = 4'b1000;
        tick(4);
        chk("nst_code3", {2'b0, code}, 4'h3);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        irq = 4'b0000;
        chk("nst_isr3", isr, 4'b1000);
        tick(1);
        irq = 4'b0010;
        tick(3);
        chk("nst_pending", pending, 4'b0010);
        irq = 4'b0000;
        tick(1);
`ifdef IRQ_CTRL_NESTING_EN
        chk("nst_req",  {3'b0, int_req}, 4'h1);
        chk("nst_code", {2'b0, code},    4'h1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("nst_isr_both", isr, 4'b1010);
        tick(1);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("nst_iret", isr, 4'b1000);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("nst_iret2", isr, 4'h0);
`else
        chk("nst_noreq", {3'b0, int_req}, 4'h0);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("nst_iret", isr, 4'h0);
        chk("nst_noreq2", {3'b0, int_req}, 4'h0);
        tick(1);
        chk("nst_req",  {3'b0, int_req}, 4'h1);
        chk("nst_code", {2'b0, code},    4'h1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("nst_isr1", isr, 4'b0010);
        tick(1);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("nst_iret2", isr, 4'h0);
`endif
        tick(2);

        // Source 0 re-edge coincides with its own ack
        irq = 4'b0001;
        tick(3);
        chk("col_pending", pending, 4'b0001);
        irq = 4'b0000;
        tick(1);
        chk("col_req",  {3'b0, int_req}, 4'h1);
        chk("col_code", {2'b0, code},    4'h0);
        tick(1);
        irq = 4'b0001;
        tick(2);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        irq = 4'b0000;
        chk("col_enter",   {3'b0, enter}, 4'h1);
        chk("col_isr",     isr,           4'b0001);
        chk("col_pending2", pending,      4'b0001);
        tick(1);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("col_iret",  isr,             4'h0);
        chk("col_noreq", {3'b0, int_req}, 4'h0);
        tick(1);
        chk("col_req2",  {3'b0, int_req}, 4'h1);
        chk("col_code2", {2'b0, code},    4'h0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk("col_isr2", isr,     4'b0001);
        chk("col_pnd2", pending, 4'h0);
        tick(1);
        iret = 1'b1;
        tick(1);
        iret = 1'b0;
        chk("col_final_isr", isr, 4'h0);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
